// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one 8N1 UART TX line
// Grants are held per packet until LAST, MAX_PKT bytes, or an idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_PKT      = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 PKT_ABORT,
  output logic                 TX
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_OWN     = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    arb_state;
  logic [1:0]    ser_state;
  logic [PW-1:0] ptr;
  logic [7:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pend;
  logic          pend_abort;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tx_q;

  logic          ser_idle;
  logic          baud_tc;
  logic          stop_done;
  logic          own_ready;
  logic          accept;
  logic [7:0]    acc_data;
  logic          acc_last;
  logic          hit_max;
  logic          tmo_cond;
  logic          tmo_fire;
  logic          found;
  logic [PW-1:0] winner;

  assign ser_idle  = (ser_state == S_IDLE);
  assign baud_tc   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign stop_done = (ser_state == S_STOP) && baud_tc;
  // A pending release blocks further accepts while the final frame drains.
  assign own_ready = (arb_state == ARB_OWN) && ser_idle && !pend;
  assign REQ_READY = GRANT & {NUM_REQ{own_ready}};
  assign accept    = own_ready && REQ_VALID[ptr];
  assign acc_data  = REQ_DATA[8*ptr +: 8];
  assign acc_last  = REQ_LAST[ptr];
  assign hit_max   = (byte_cnt == 8'(MAX_PKT - 1));
  assign tmo_cond  = own_ready && !REQ_VALID[ptr];
  assign tmo_fire  = tmo_cond && (tmo_cnt == TW'(IDLE_TIMEOUT - 1));
  assign BUSY      = (arb_state != ARB_IDLE) || (ser_state != S_IDLE);
  assign TX        = tx_q;

  always_comb begin
    logic [PW-1:0] cand;
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && REQ_VALID[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      arb_state  <= ARB_IDLE;
      GRANT      <= '0;
      ptr        <= PW'(NUM_REQ - 1);
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      pend       <= 1'b0;
      pend_abort <= 1'b0;
      PKT_ABORT  <= 1'b0;
    end else begin
      PKT_ABORT <= 1'b0;
      case (arb_state)
        ARB_IDLE: begin
          if (found) begin
            GRANT      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            ptr        <= winner;
            arb_state  <= ARB_OWN;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            pend       <= 1'b0;
            pend_abort <= 1'b0;
          end
        end
        ARB_OWN: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 8'd1;
            tmo_cnt  <= '0;
            if (acc_last || hit_max) begin
              pend       <= 1'b1;
              pend_abort <= !acc_last;
            end
          end else if (pend && stop_done) begin
            arb_state <= ARB_RELEASE;
            GRANT     <= '0;
            PKT_ABORT <= pend_abort;
          end else if (tmo_fire) begin
            arb_state <= ARB_RELEASE;
            GRANT     <= '0;
            PKT_ABORT <= 1'b1;
          end else if (tmo_cond) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end else begin
            tmo_cnt <= '0;
          end
        end
        ARB_RELEASE: arb_state <= ARB_IDLE;
        default:     arb_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ser_state <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (ser_state)
        S_IDLE: begin
          if (accept) begin
            shreg     <= acc_data;
            ser_state <= S_START;
            baud_cnt  <= '0;
            tx_q      <= 1'b0;
          end
        end
        S_START: begin
          if (baud_tc) begin
            ser_state <= S_DATA;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ser_state <= S_STOP;
              tx_q      <= 1'b1;
            end else begin
              shreg <= shreg >> 1;
              tx_q  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_tc) begin
            ser_state <= S_IDLE;
            baud_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
// A UART receiver model pops expected {requester, byte} entries per decoded frame.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic [3:0]  grant;
  logic        busy;
  logic        pkt_abort;
  logic        tx;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int rst_cnt = 0;
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(4), .CLKS_PER_BIT(4), .MAX_PKT(3), .IDLE_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(valid), .REQ_DATA(data),
    .REQ_LAST(last), .REQ_READY(ready), .GRANT(grant), .BUSY(busy),
    .PKT_ABORT(pkt_abort), .TX(tx)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(posedge RESET) rst_cnt++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] idx_of(logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Drive a byte and hold it until accepted; returns on the negedge after the accept edge.
  task automatic put(int r, logic [7:0] d, logic l);
    int n = 0;
    valid[r] = 1'b1;
    data[8*r +: 8] = d;
    last[r] = l;
    while (ready[r] !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("put_ready", 32'(ready[r]), 32'd1);
    if (ready[r] === 1'b1) exp_q.push_back({2'(r), d});
    @(negedge CLK);
  endtask

  task automatic drop(int r);
    valid[r] = 1'b0;
    last[r]  = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    valid = '0;
    last  = '0;
    data  = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [1:0] gidx;
    logic [9:0] e;
    int snap;
    logic ok, start_ok, stop_ok;
    forever begin
      @(negedge CLK);
      if (tx === 1'b0 && RESET === 1'b0) begin
        snap = rst_cnt; ok = 1'b1; gidx = idx_of(grant);
        start_ok = 1'b0; stop_ok = 1'b0; b = '0;
        for (int t = 1; t <= 38 && ok; t++) begin
          @(negedge CLK);
          if (rst_cnt != snap) ok = 1'b0;
          else if (t == 2) start_ok = (tx === 1'b0);
          else if (t >= 6 && t <= 34 && ((t - 6) % 4) == 0) b[(t-6)/4] = tx;
          else if (t == 38) stop_ok = (tx === 1'b1);
        end
        if (ok) begin
          check("start_bit", 32'(start_ok), 32'd1);
          check("stop_bit", 32'(stop_ok), 32'd1);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
          check("frame", 32'({gidx, b}), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    logic [9:0] seq;
    int t1, t2, t3, n;

    do_reset();
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(pkt_abort), 32'd0);
    @(negedge CLK);

    // Single byte 0xA5 from requester 0, bit-exact TX waveform.
    valid[0] = 1'b1; data[7:0] = 8'hA5; last[0] = 1'b1;
    @(negedge CLK);
    check("s1_grant", 32'(grant), 32'h1);
    check("s1_ready", 32'(ready), 32'h1);
    put(0, 8'hA5, 1'b1);
    drop(0);
    seq = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("s1_txbit%0d", k), 32'(tx), 32'(seq[k]));
      repeat (4) @(negedge CLK);
    end
    check("s1_rel_grant", 32'(grant), 32'd0);
    check("s1_rel_abort", 32'(pkt_abort), 32'd0);
    check("s1_rel_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("s1_idle_busy", 32'(busy), 32'd0);

    // Requesters 1 and 3 from reset: order 1, 3, 1.
    do_reset();
    valid[3] = 1'b1; data[31:24] = 8'h43; last[3] = 1'b1;
    valid[1] = 1'b1; data[15:8] = 8'h41; last[1] = 1'b1;
    @(negedge CLK);
    check("s2_first_grant", 32'(grant), 32'h2);
    put(1, 8'h41, 1'b1);
    data[15:8] = 8'h42;
    put(3, 8'h43, 1'b1);
    check("s2_second_grant", 32'(grant), 32'h8);
    drop(3);
    put(1, 8'h42, 1'b1);
    drop(1);
    repeat (42) @(negedge CLK);

    // Requester 2 streams three bytes while requester 0 waits; LAST coincides with MAX_PKT.
    valid[0] = 1'b1; data[7:0] = 8'h50; last[0] = 1'b1;
    put(2, 8'h11, 1'b0); t1 = cyc;
    put(2, 8'h22, 1'b0); t2 = cyc;
    put(2, 8'h33, 1'b1); t3 = cyc;
    drop(2);
    check("s3_gap12", 32'(t2 - t1), 32'd41);
    check("s3_gap23", 32'(t3 - t2), 32'd41);
    repeat (40) @(negedge CLK);
    check("s3_rel_grant", 32'(grant), 32'd0);
    check("s3_rel_abort", 32'(pkt_abort), 32'd0);
    @(negedge CLK);
    check("s3_idle_grant", 32'(grant), 32'd0);
    @(negedge CLK);
    check("s3_next_grant", 32'(grant), 32'h1);
    put(0, 8'h50, 1'b1);
    drop(0);
    repeat (42) @(negedge CLK);

    // MAX_PKT forced release without LAST, then regrant for the remainder.
    put(0, 8'h61, 1'b0);
    put(0, 8'h62, 1'b0);
    put(0, 8'h63, 1'b0);
    data[7:0] = 8'h64; last[0] = 1'b1;
    repeat (40) @(negedge CLK);
    check("s4_abort_pulse", 32'(pkt_abort), 32'd1);
    check("s4_rel_grant", 32'(grant), 32'd0);
    @(negedge CLK);
    check("s4_abort_end", 32'(pkt_abort), 32'd0);
    put(0, 8'h64, 1'b1);
    drop(0);
    repeat (42) @(negedge CLK);

    // Idle timeout after a byte without LAST.
    put(1, 8'h71, 1'b0);
    drop(1);
    repeat (47) @(negedge CLK);
    check("s5_hold_grant", 32'(grant), 32'h2);
    check("s5_hold_abort", 32'(pkt_abort), 32'd0);
    @(negedge CLK);
    check("s5_tmo_grant", 32'(grant), 32'd0);
    check("s5_tmo_abort", 32'(pkt_abort), 32'd1);
    @(negedge CLK);
    check("s5_abort_end", 32'(pkt_abort), 32'd0);
    check("s5_idle_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);

    // Reset during data bit 3 kills the frame; requester 0 wins afterwards.
    put(2, 8'h96, 1'b1);
    drop(2);
    void'(exp_q.pop_back());
    repeat (17) @(negedge CLK);
    check("s6_busy_before", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1;
    check("s6_rst_tx", 32'(tx), 32'd1);
    check("s6_rst_grant", 32'(grant), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_ready", 32'(ready), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    valid[0] = 1'b1; data[7:0] = 8'hC3; last[0] = 1'b1;
    valid[2] = 1'b1; data[23:16] = 8'h3C; last[2] = 1'b1;
    @(negedge CLK);
    check("s6_first_grant", 32'(grant), 32'h1);
    put(0, 8'hC3, 1'b1);
    drop(0);
    put(2, 8'h3C, 1'b1);
    drop(2);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
